// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer and the count-up stopwatch:
// time field widths, per-field maxima used for borrow/carry wrap and preset
// clamping, and the timer control state encoding.
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MS_W   = 10;

    localparam logic [MS_W-1:0]   MS_MAX   = 10'd999;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a single-cycle tick. The count runs
// 0..DIV-1 while enabled and holds its value while disabled, so a pause keeps
// the partial period. clr_i takes precedence over en_i and suppresses tick_o.
//
// Ports:
//   clk_i   in  1  system clock
//   reset_i in  1  asynchronous, active-low reset
//   en_i    in  1  count enable
//   clr_i   in  1  synchronous clear of the count
//   tick_o  out 1  high for the cycle in which the count is at DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && !clr_i && (cnt_q == TERM);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_hms.sv
// ---------------------------------------------------------------------------
// countdown_timer_hms
// Preset countdown timer with millisecond resolution. load_i copies the
// (clamped) hour/min/sec presets into the counter; a rising edge on
// start_stop_i starts, pauses and resumes the countdown. Reaching
// 00:00:00.000 gives a one-cycle done_o pulse and holds expired_o high until
// the next load.
//
// Ports:
//   clk_i        in  1   system clock
//   reset_i      in  1   asynchronous, active-low reset
//   load_i       in  1   synchronous load strobe (highest priority)
//   start_stop_i in  1   start/pause control, rising edge acts
//   Hourset      in  5   preset hours   (values >23 load 23)
//   Minset       in  6   preset minutes (values >59 load 59)
//   Secset       in  6   preset seconds (values >59 load 59)
//   hour_o       out 5   remaining hours
//   min_o        out 6   remaining minutes
//   sec_o        out 6   remaining seconds
//   ms_o         out 10  remaining milliseconds, 0..999
//   running_o    out 1   high while counting down
//   done_o       out 1   one-cycle pulse on reaching zero
//   expired_o    out 1   high while expired
// ---------------------------------------------------------------------------
module countdown_timer_hms
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              start_stop_i,
    input  logic [HOUR_W-1:0] Hourset,
    input  logic [MIN_W-1:0]  Minset,
    input  logic [SEC_W-1:0]  Secset,
    output logic [HOUR_W-1:0] hour_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MS_W-1:0]   ms_o,
    output logic              running_o,
    output logic              done_o,
    output logic              expired_o
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    timer_state_t      state_q;
    logic              ss_q;
    logic              done_q;
    logic [HOUR_W-1:0] hour_q, hour_d, hour_ld;
    logic [MIN_W-1:0]  min_q,  min_d,  min_ld;
    logic [SEC_W-1:0]  sec_q,  sec_d,  sec_ld;
    logic [MS_W-1:0]   ms_q,   ms_d;

    logic ss_rise;
    logic cnt_zero;
    logic dec_zero;
    logic tick;
    logic presc_en;
    logic presc_clr;

    assign ss_rise  = start_stop_i & ~ss_q;
    assign cnt_zero = (hour_q == '0) && (min_q == '0) && (sec_q == '0) && (ms_q == '0);

    // Load and ss_rise both outrank the tick, so the prescaler is frozen in
    // those cycles rather than losing a partially counted period.
    assign presc_en  = (state_q == RUN) && !load_i && !ss_rise;
    assign presc_clr = load_i || ((state_q == IDLE) && ss_rise && !cnt_zero);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (presc_en),
        .clr_i   (presc_clr),
        .tick_o  (tick)
    );

    assign hour_ld = (Hourset > HOUR_MAX) ? HOUR_MAX : Hourset;
    assign min_ld  = (Minset  > MIN_MAX)  ? MIN_MAX  : Minset;
    assign sec_ld  = (Secset  > SEC_MAX)  ? SEC_MAX  : Secset;

    // Borrow chain ms -> sec -> min -> hour. Only used from RUN, which is
    // never occupied with an all-zero count, so hour never wraps.
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        ms_d   = ms_q;
        if (ms_q != '0) begin
            ms_d = ms_q - MS_W'(1);
        end else begin
            ms_d = MS_MAX;
            if (sec_q != '0) begin
                sec_d = sec_q - SEC_W'(1);
            end else begin
                sec_d = SEC_MAX;
                if (min_q != '0) begin
                    min_d = min_q - MIN_W'(1);
                end else begin
                    min_d  = MIN_MAX;
                    hour_d = hour_q - HOUR_W'(1);
                end
            end
        end
    end

    assign dec_zero = (hour_d == '0) && (min_d == '0) && (sec_d == '0) && (ms_d == '0);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ss_q    <= 1'b0;
            done_q  <= 1'b0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            ms_q    <= '0;
        end else begin
            ss_q   <= start_stop_i;
            done_q <= 1'b0;
            if (load_i) begin
                hour_q  <= hour_ld;
                min_q   <= min_ld;
                sec_q   <= sec_ld;
                ms_q    <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ss_rise && !cnt_zero) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (ss_rise) begin
                            state_q <= PAUSE;
                        end else if (tick) begin
                            hour_q <= hour_d;
                            min_q  <= min_d;
                            sec_q  <= sec_d;
                            ms_q   <= ms_d;
                            if (dec_zero) begin
                                state_q <= EXPIRED;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (ss_rise) begin
                            state_q <= RUN;
                        end
                    end
                    default: begin
                        // EXPIRED: hold at zero until the next load
                    end
                endcase
            end
        end
    end

    assign hour_o    = hour_q;
    assign min_o     = min_q;
    assign sec_o     = sec_q;
    assign ms_o      = ms_q;
    assign running_o = (state_q == RUN);
    assign expired_o = (state_q == EXPIRED);
    assign done_o    = done_q;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_hms
// Directed bench for countdown_timer_hms with CLK_HZ=4, TICK_HZ=1 (DIV=4).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_countdown_timer_hms;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        load_i;
    logic        start_stop_i;
    logic [4:0]  Hourset;
    logic [5:0]  Minset;
    logic [5:0]  Secset;
    logic [4:0]  hour_o;
    logic [5:0]  min_o;
    logic [5:0]  sec_o;
    logic [9:0]  ms_o;
    logic        running_o;
    logic        done_o;
    logic        expired_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    countdown_timer_hms #(
        .CLK_HZ  (4),
        .TICK_HZ (1)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (load_i),
        .start_stop_i (start_stop_i),
        .Hourset      (Hourset),
        .Minset       (Minset),
        .Secset       (Secset),
        .hour_o       (hour_o),
        .min_o        (min_o),
        .sec_o        (sec_o),
        .ms_o         (ms_o),
        .running_o    (running_o),
        .done_o       (done_o),
        .expired_o    (expired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
        chk({tag, ".hour"}, 32'(hour_o), 32'(h));
        chk({tag, ".min"},  32'(min_o),  32'(m));
        chk({tag, ".sec"},  32'(sec_o),  32'(s));
        chk({tag, ".ms"},   32'(ms_o),   32'(ms));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        Hourset = 5'(h);
        Minset  = 6'(m);
        Secset  = 6'(s);
        load_i  = 1'b1;
        cyc(1);
        load_i  = 1'b0;
    endtask

    task automatic pulse_ss();
        start_stop_i = 1'b1;
        cyc(1);
        start_stop_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b0;
        load_i       = 1'b0;
        start_stop_i = 1'b0;
        Hourset      = '0;
        Minset       = '0;
        Secset       = '0;

        // ---- reset state ----
        cyc(2);
        reset_i = 1'b1;
        cyc(1);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.running", 32'(running_o), 0);
        chk("reset.done",    32'(done_o),    0);
        chk("reset.expired", 32'(expired_o), 0);

        // ---- load 0:00:01 and run to zero ----
        do_load(0, 0, 1);
        chk_time("load1", 0, 0, 1, 0);
        chk("load1.running", 32'(running_o), 0);
        pulse_ss();                       // edge N: RUN entered
        chk("start.running", 32'(running_o), 1);
        cyc(3);                           // edge N+3: no tick yet
        chk_time("pre_tick", 0, 0, 1, 0);
        cyc(1);                           // edge N+4: first decrement
        chk_time("first_tick", 0, 0, 0, 999);
        cyc(3995);                        // edge N+3999
        chk_time("last_ms", 0, 0, 0, 1);
        chk("last_ms.done", 32'(done_o), 0);
        cyc(1);                           // edge N+4000: reaches zero
        chk_time("zero", 0, 0, 0, 0);
        chk("zero.done",    32'(done_o),    1);
        chk("zero.expired", 32'(expired_o), 1);
        chk("zero.running", 32'(running_o), 0);
        cyc(1);
        chk("after.done",    32'(done_o),    0);
        chk("after.expired", 32'(expired_o), 1);
        pulse_ss();
        cyc(8);
        chk("exp_ss.expired", 32'(expired_o), 1);
        chk("exp_ss.running", 32'(running_o), 0);
        chk("exp_ss.done",    32'(done_o),    0);
        chk_time("exp_ss", 0, 0, 0, 0);

        // ---- borrow chain: 1:00:00 -> 0:59:59.999 ----
        do_load(1, 0, 0);
        chk("reload.expired", 32'(expired_o), 0);
        pulse_ss();
        cyc(4);
        chk_time("borrow", 0, 59, 59, 999);

        // ---- load and start_stop rise together in RUN: load wins ----
        Hourset      = 5'd2;
        Minset       = 6'd3;
        Secset       = 6'd4;
        load_i       = 1'b1;
        start_stop_i = 1'b1;
        cyc(1);
        load_i       = 1'b0;
        start_stop_i = 1'b0;
        chk_time("prio", 2, 3, 4, 0);
        chk("prio.running", 32'(running_o), 0);
        cyc(1);
        chk("prio_hold.running", 32'(running_o), 0);

        // ---- start_stop held high 50 cycles: single start ----
        start_stop_i = 1'b1;
        cyc(1);
        chk("held.running_start", 32'(running_o), 1);
        cyc(49);                          // 12 ticks in 50 cycles
        chk("held.running_end", 32'(running_o), 1);
        chk_time("held", 2, 3, 3, 988);
        start_stop_i = 1'b0;

        // ---- pause/resume keeps the prescaler fraction ----
        do_load(0, 0, 1);
        pulse_ss();                       // edge N
        cyc(46);                          // 11 ticks plus 2 prescaler cycles
        chk_time("pre_pause", 0, 0, 0, 989);
        pulse_ss();                       // edge N+47: PAUSE
        chk("pause.running", 32'(running_o), 0);
        cyc(100);
        chk_time("paused", 0, 0, 0, 989);
        chk("paused.running", 32'(running_o), 0);
        pulse_ss();                       // edge R: RUN again
        chk("resume.running", 32'(running_o), 1);
        chk("resume.ms", 32'(ms_o), 989);
        cyc(1);
        chk("resume1.ms", 32'(ms_o), 989);
        cyc(1);
        chk("resume2.ms", 32'(ms_o), 988);

        // ---- clamp and zero-count start ----
        do_load(31, 63, 60);
        chk_time("clamp", 23, 59, 59, 0);
        chk("clamp.running", 32'(running_o), 0);
        do_load(0, 0, 0);
        pulse_ss();
        chk("zero_start.running", 32'(running_o), 0);
        cyc(5);
        chk("zero_start2.running", 32'(running_o), 0);
        chk("zero_start.expired",  32'(expired_o), 0);
        chk_time("zero_start", 0, 0, 0, 0);

        // ---- asynchronous reset mid-count at 0:00:05.123 ----
        do_load(0, 0, 6);
        pulse_ss();
        cyc(3508);                        // 877 ticks
        chk_time("pre_reset", 0, 0, 5, 123);
        #1;
        reset_i = 1'b0;
        #2;                               // mid-cycle, no clock edge yet
        chk_time("async_reset", 0, 0, 0, 0);
        chk("async_reset.running", 32'(running_o), 0);
        chk("async_reset.expired", 32'(expired_o), 0);
        chk("async_reset.done",    32'(done_o),    0);
        cyc(1);
        reset_i = 1'b1;
        cyc(6);
        chk_time("post_reset", 0, 0, 0, 0);
        chk("post_reset.running", 32'(running_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
